vga_plotter: RTL and testbench

Command-driven rectangle fill engine that sources plot requests for the VGA adapter wrapper. It accepts one rectangle command (origin, size, colour), clips it to the 160x120 frame, and emits one pixel write (x, y, colour, plot) per clock in row-major order. It sits between control logic (CPU I/O port or test FSM) and the `vga` wrapper. Typical uses are screen clears and block sprites.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_scan_counter.sv | 78 +++++++
 rtl/vga_plotter.sv | 143 ++++++++++++++
 tb/tb_vga_plotter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA drawing blocks.
// Provides frame defaults, coordinate/colour widths and the common
// drawing-engine state encoding.
package vga_pkg;

   localparam int unsigned XMAX_DEF = 160;
   localparam int unsigned YMAX_DEF = 120;
   localparam int unsigned X_W      = 8;
   localparam int unsigned Y_W      = 7;
   localparam int unsigned COL_W    = 3;

   // Drawing-engine states, shared by later VGA drawing blocks.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } vga_state_e;

   // One pixel write as presented to the adapter.
   typedef struct packed {
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [COL_W-1:0] colour;
   } vga_pixel_t;

endpackage

// File: rtl/vga_scan_counter.sv
// Row-major x/y scan counter for rectangle fills.
// Ports:
//   clock, reset       - clock, asynchronous active-high reset
//   load               - capture x0/y0/x_last/y_last, counters := (x0, y0)
//   enable             - advance one pixel (x++, wrap to x0 and y++ at x_last)
//   x0, y0             - rectangle origin
//   x_last, y_last     - inclusive clipped rectangle bounds
//   x, y               - current pixel (registered)
//   last               - current pixel is the final one of the rectangle
module vga_scan_counter
   import vga_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           load,
   input  logic           enable,
   input  logic [X_W-1:0] x0,
   input  logic [Y_W-1:0] y0,
   input  logic [X_W-1:0] x_last,
   input  logic [Y_W-1:0] y_last,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [X_W-1:0] x0_q, x0_d;
   logic [X_W-1:0] x_last_q, x_last_d;
   logic [Y_W-1:0] y_last_q, y_last_d;
   logic           row_end;

   assign row_end = (x_q == x_last_q);

   // Next-count logic: load wins over enable; row wrap reloads x0.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      x0_d     = x0_q;
      x_last_d = x_last_q;
      y_last_d = y_last_q;
      if (load) begin
         x_d      = x0;
         y_d      = y0;
         x0_d     = x0;
         x_last_d = x_last;
         y_last_d = y_last;
      end else if (enable) begin
         if (row_end) begin
            x_d = x0_q;
            y_d = y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_q      <= '0;
         y_q      <= '0;
         x0_q     <= '0;
         x_last_q <= '0;
         y_last_q <= '0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         x0_q     <= x0_d;
         x_last_q <= x_last_d;
         y_last_q <= y_last_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = row_end && (y_q == y_last_q);

endmodule

// File: rtl/vga_plotter.sv
// Rectangle fill engine: accepts one clipped rectangle command and emits
// one pixel write per clock in row-major order for the VGA adapter.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   start                 - command strobe, honoured only when idle
//   x0, y0, w, h          - rectangle origin and size (w/h of 0 = empty)
//   colour_in             - fill colour
//   x, y, colour, plot    - registered pixel write to the adapter
//   busy                  - command in progress
//   done                  - one-cycle completion pulse
module vga_plotter
   import vga_pkg::*;
#(
   parameter int unsigned XMAX = XMAX_DEF,
   parameter int unsigned YMAX = YMAX_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [X_W-1:0]   x0,
   input  logic [Y_W-1:0]   y0,
   input  logic [X_W-1:0]   w,
   input  logic [Y_W-1:0]   h,
   input  logic [COL_W-1:0] colour_in,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic [COL_W-1:0] colour,
   output logic             plot,
   output logic             busy,
   output logic             done
);

   vga_state_e       state_q, state_d;
   logic [COL_W-1:0] colour_q, colour_d;
   logic             plot_q, plot_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cnt_load;
   logic             cnt_enable;
   logic             cnt_last;
   logic [X_W-1:0]   cnt_x;
   logic [Y_W-1:0]   cnt_y;

   // One extra bit of headroom so x0+w / y0+h cannot wrap before clipping.
   logic [X_W:0]     x_end;
   logic [Y_W:0]     y_end;
   logic [X_W-1:0]   x_last;
   logic [Y_W-1:0]   y_last;
   logic             empty_cmd;

   always_comb begin
      x_end  = (X_W+1)'(x0) + (X_W+1)'(w) - (X_W+1)'(1);
      y_end  = (Y_W+1)'(y0) + (Y_W+1)'(h) - (Y_W+1)'(1);
      x_last = (x_end > (X_W+1)'(XMAX - 1)) ? X_W'(XMAX - 1) : x_end[X_W-1:0];
      y_last = (y_end > (Y_W+1)'(YMAX - 1)) ? Y_W'(YMAX - 1) : y_end[Y_W-1:0];
      empty_cmd = (w == '0) || (h == '0) ||
                  ((X_W+1)'(x0) >= (X_W+1)'(XMAX)) ||
                  ((Y_W+1)'(y0) >= (Y_W+1)'(YMAX));
   end

   vga_scan_counter u_scan (
      .clock  (clock),
      .reset  (reset),
      .load   (cnt_load),
      .enable (cnt_enable),
      .x0     (x0),
      .y0     (y0),
      .x_last (x_last),
      .y_last (y_last),
      .x      (cnt_x),
      .y      (cnt_y),
      .last   (cnt_last)
   );

   // Next state and next registered outputs. Colour is only latched for
   // non-empty commands so idle outputs keep the last plotted pixel.
   always_comb begin
      state_d    = state_q;
      colour_d   = colour_q;
      plot_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      cnt_load   = 1'b0;
      cnt_enable = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (empty_cmd) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = DRAW;
                  cnt_load = 1'b1;
                  colour_d = colour_in;
                  plot_d   = 1'b1;
                  busy_d   = 1'b1;
               end
            end
         end
         DRAW: begin
            if (cnt_last) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               cnt_enable = 1'b1;
               plot_d     = 1'b1;
               busy_d     = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign x      = cnt_x;
   assign y      = cnt_y;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_vga_plotter.sv
// Self-checking bench for vga_plotter: directed and random rectangle
// commands compared against a pixel-list reference model.
module tb_vga_plotter;
   import vga_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] x0_i;
   logic [6:0] y0_i;
   logic [7:0] w_i;
   logic [6:0] h_i;
   logic [2:0] colour_in;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;

   int checks = 0;
   int errors = 0;

   // Last plotted pixel; outputs must hold this while plot is low.
   logic [17:0] hold_pix = '0;

   always #5 clock = ~clock;

   vga_plotter dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .x0        (x0_i),
      .y0        (y0_i),
      .w         (w_i),
      .h         (h_i),
      .colour_in (colour_in),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one command and check every cycle until back in IDLE.
   task automatic run_cmd(input int cx0, input int cy0, input int cw, input int ch,
                          input int cc, input bit perturb);
      logic [17:0] exp_q[$];
      int xe, ye;
      xe = cx0 + cw; if (xe > 160) xe = 160;
      ye = cy0 + ch; if (ye > 120) ye = 120;
      for (int yy = cy0; yy < ye; yy++)
         for (int xx = cx0; xx < xe; xx++)
            exp_q.push_back({8'(xx), 7'(yy), 3'(cc)});

      x0_i = 8'(cx0); y0_i = 7'(cy0); w_i = 8'(cw); h_i = 7'(ch);
      colour_in = 3'(cc);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (perturb && i == 1) begin
            start = 1'b1; x0_i = ~x0_i; colour_in = ~colour_in; y0_i = 7'd0;
         end
         if (perturb && i == 2) start = 1'b0;
         check($sformatf("pixel%0d@(%0d,%0d,%0d,%0d)", i, cx0, cy0, cw, ch),
               {plot, busy, done, x, y, colour}, {3'b110, exp_q[i]});
         step();
      end
      start = 1'b0;
      if (exp_q.size() > 0) hold_pix = exp_q[exp_q.size()-1];
      check($sformatf("done@(%0d,%0d,%0d,%0d)", cx0, cy0, cw, ch),
            {plot, busy, done, x, y, colour}, {3'b001, hold_pix});
      step();
      check("idle_after_done", {plot, busy, done, x, y, colour}, {3'b000, hold_pix});
   endtask

   initial begin
      // Reset held with start asserted: all outputs low/zero.
      reset = 1'b1; start = 1'b1;
      x0_i = 8'd3; y0_i = 7'd3; w_i = 8'd4; h_i = 7'd4; colour_in = 3'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_outputs", {plot, busy, done, x, y, colour}, 32'd0);
      end
      reset = 1'b0; start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("quiet_after_reset", {plot, busy, done, x, y, colour}, 32'd0);
      end

      run_cmd(10, 5, 3, 2, 5, 1'b0);      // basic fill
      run_cmd(158, 118, 5, 4, 3, 1'b0);   // clipped at both edges
      run_cmd(200, 10, 4, 4, 6, 1'b0);    // x0 off-screen
      run_cmd(5, 120, 4, 4, 6, 1'b0);     // y0 off-screen
      run_cmd(20, 20, 0, 5, 1, 1'b0);     // w = 0
      run_cmd(20, 20, 5, 0, 1, 1'b0);     // h = 0
      run_cmd(255, 127, 255, 127, 4, 1'b0); // maximal operands, no wrap
      run_cmd(159, 119, 1, 1, 2, 1'b0);   // single corner pixel
      run_cmd(20, 30, 6, 4, 2, 1'b1);     // start/input changes mid-draw

      for (int n = 0; n < 25; n++) begin
         run_cmd(int'($urandom_range(170, 0)), int'($urandom_range(125, 0)),
                 int'($urandom_range(12, 0)), int'($urandom_range(6, 0)),
                 int'($urandom_range(7, 0)), 1'b0);
      end

      run_cmd(0, 0, 160, 120, 7, 1'b0);   // full clear

      // Reset mid-draw: plot drops immediately, no done afterwards.
      x0_i = 8'd40; y0_i = 7'd40; w_i = 8'd10; h_i = 7'd10; colour_in = 3'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("abort_pre_plot", {plot, busy, x, y}, {2'b11, 8'd41, 7'd40});
      reset = 1'b1;
      #1;
      check("abort_async", {plot, busy, done, x, y, colour}, 32'd0);
      step();
      reset = 1'b0;
      hold_pix = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("abort_quiet", {plot, busy, done, x, y, colour}, 32'd0);
      end
      run_cmd(1, 2, 2, 2, 1, 1'b0);       // recovers after abort

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
